// File: rtl/md_pkg.sv
// md_pkg: op codes, state encoding and op-class helpers for the E-stage mult/div sequencer.
package md_pkg;
    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_NONE  = 4'hF;

    typedef enum logic {ST_IDLE, ST_RUN} md_state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return op == MD_MULT || op == MD_MULTU;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return op == MD_MTHI || op == MD_MTLO;
    endfunction
endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E/D-stage request side and mult/div unit control side of the sequencer.
interface md_sched_if;
    logic        e_md_valid;
    logic [3:0]  e_md_op;
    logic        int_req;
    logic        d_md_use;
    logic        md_start;
    logic [3:0]  md_op;
    logic        md_busy;
    logic        stall;
    logic        done;
    logic        proto_err;
    logic [15:0] stall_cnt;

    modport master (
        output e_md_valid, e_md_op, int_req, d_md_use,
        input  md_start, md_op, md_busy, stall, done, proto_err, stall_cnt
    );

    modport slave (
        input  e_md_valid, e_md_op, int_req, d_md_use,
        output md_start, md_op, md_busy, stall, done, proto_err, stall_cnt
    );
endinterface

// File: rtl/md_lat_counter.sv
// md_lat_counter: loadable 5-bit latency down-counter flagging the final busy cycle.
module md_lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [4:0] i_load_val,
    input  logic       i_en,
    output logic       o_last
);
    logic [4:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= 5'd0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && r_cnt != 5'd0)
            r_cnt <= r_cnt - 5'd1;
    end

    assign o_last = r_cnt == 5'd1;
endmodule

// File: rtl/md_sched.sv
// md_sched: issues mult/div/mt ops to the unit, tracks latency, and raises HI/LO hazard stalls.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.slave bus
);
    md_state_t   r_state;
    logic        r_done;
    logic        r_proto_err;
    logic [15:0] r_stall_cnt;
    logic        w_legal;
    logic        w_accept;
    logic        w_load;
    logic        w_last;
    logic        w_run;
    logic        w_stall;
    logic [4:0]  w_load_val;

    assign w_run      = r_state == ST_RUN;
    assign w_legal    = is_mul(bus.e_md_op) | is_div(bus.e_md_op) | is_mt(bus.e_md_op);
    // A pending interrupt flushes the E-stage instruction, so it must not issue.
    assign w_accept   = bus.e_md_valid & ~bus.int_req & ~w_run & w_legal;
    assign w_load     = w_accept & (is_mul(bus.e_md_op) | is_div(bus.e_md_op));
    assign w_load_val = is_div(bus.e_md_op) ? 5'(DIV_LAT) : 5'(MULT_LAT);
    assign w_stall    = bus.d_md_use & (w_run | w_accept);

    md_lat_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .i_en      (w_run),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state     <= w_load ? ST_RUN : (w_run && w_last) ? ST_IDLE : r_state;
            r_done      <= w_run && w_last;
            r_proto_err <= r_proto_err | (bus.e_md_valid & (w_run | ~w_legal));
            r_stall_cnt <= r_stall_cnt + {15'd0, w_stall & ~&r_stall_cnt};
        end
    end

    assign bus.md_start  = w_accept;
    assign bus.md_op     = w_accept ? bus.e_md_op : MD_NONE;
    assign bus.md_busy   = w_run;
    assign bus.stall     = w_stall;
    assign bus.done      = r_done;
    assign bus.proto_err = r_proto_err;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
